// File: rtl/core_pkg.sv
// core_pkg: shared types and constants for the RV32IM in-order pipeline.
//   - fw_ctrltype : forwarding candidate published by EXE, MEM and WB
//   - ctrltype    : decoded control bundle handed from ID to EXE
//   - MEN_*/REN_*/WB_*/CSR_*/ALU_* encodings
//   - opcode / funct3 / funct7 constants and immediate-extraction helpers
package core_pkg;

  localparam int XLEN = 32;

  // Major opcodes (inst[6:0])
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  // funct7 variants of OP / OP-IMM shifts
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // funct3 of MISC-MEM
  localparam logic [2:0] F3_FENCE   = 3'b000;
  localparam logic [2:0] F3_FENCE_I = 3'b001;

  // Whole-word encodings of the privileged SYSTEM instructions
  localparam logic [31:0] INST_ECALL = 32'h0000_0073;
  localparam logic [31:0] INST_MRET  = 32'h3020_0073;

  typedef enum logic [4:0] {
    ALU_X, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU,
    ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU,
    ALU_JALR, ALU_COPY1,
    ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
    ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
  } alu_fun_e;

  typedef enum logic [3:0] {
    MEN_X, MEN_SB, MEN_SH, MEN_SW,
    MEN_LB, MEN_LBU, MEN_LH, MEN_LHU, MEN_LW
  } mem_wen_e;

  typedef enum logic {REN_X, REN_S} rf_wen_e;

  typedef enum logic [2:0] {WB_X, WB_ALU, WB_MEM, WB_PC, WB_CSR} wb_sel_e;

  typedef enum logic [2:0] {
    CSR_X, CSR_W, CSR_S, CSR_C, CSR_ECALL, CSR_MRET
  } csr_cmd_e;

  typedef struct packed {
    logic            valid;
    logic            can_forward;
    logic [4:0]      addr;
    logic [XLEN-1:0] wdata;
  } fw_ctrltype;

  typedef struct packed {
    alu_fun_e        exe_fun;
    logic [XLEN-1:0] op1_data;
    logic [XLEN-1:0] op2_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_j;
    logic            br_flg;
    logic            jmp_flg;
    mem_wen_e        mem_wen;
    rf_wen_e         rf_wen;
    wb_sel_e         wb_sel;
    logic [4:0]      wb_addr;
    csr_cmd_e        csr_cmd;
    logic [11:0]     csr_addr;
  } ctrltype;

  // Sign-extended immediates of each instruction format.
  function automatic logic [XLEN-1:0] imm_i_of(input logic [31:0] inst);
    return {{20{inst[31]}}, inst[31:20]};
  endfunction

  function automatic logic [XLEN-1:0] imm_s_of(input logic [31:0] inst);
    return {{20{inst[31]}}, inst[31:25], inst[11:7]};
  endfunction

  function automatic logic [XLEN-1:0] imm_b_of(input logic [31:0] inst);
    return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

  function automatic logic [XLEN-1:0] imm_u_of(input logic [31:0] inst);
    return {inst[31:12], 12'h000};
  endfunction

  function automatic logic [XLEN-1:0] imm_j_of(input logic [31:0] inst);
    return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/decode_stage_operand_forward.sv
// operand_forward: resolves one source register of the ID instruction.
//   rs       in  5        source register index
//   exe_fw   in  fw_ctrl  youngest forwarding candidate (EXE)
//   mem_fw   in  fw_ctrl  MEM candidate
//   wb_fw    in  fw_ctrl  oldest candidate (WB)
//   rf_data  in  32       architectural register file value of rs
//   data     out 32       resolved operand value
//   hazard   out 1        the youngest producer of rs cannot forward yet
// Only the youngest matching entry counts; an older entry never overrides it
// even when the younger one is unable to forward.
module operand_forward
  import core_pkg::*;
(
  input  logic [4:0]      rs,
  input  fw_ctrltype      exe_fw,
  input  fw_ctrltype      mem_fw,
  input  fw_ctrltype      wb_fw,
  input  logic [XLEN-1:0] rf_data,
  output logic [XLEN-1:0] data,
  output logic            hazard
);

  logic exe_hit;
  logic mem_hit;
  logic wb_hit;

  assign exe_hit = exe_fw.valid && (exe_fw.addr == rs);
  assign mem_hit = mem_fw.valid && (mem_fw.addr == rs);
  assign wb_hit  = wb_fw.valid  && (wb_fw.addr  == rs);

  // NOTE: defaults come first so every path assigns every output; a missed
  // branch in always_comb would otherwise infer a latch.
  always_comb begin
    data   = rf_data;
    hazard = 1'b0;
    if (rs == 5'd0) begin
      data = '0;
    end else if (exe_hit) begin
      if (exe_fw.can_forward) data = exe_fw.wdata;
      else                    hazard = 1'b1;
    end else if (mem_hit) begin
      if (mem_fw.can_forward) data = mem_fw.wdata;
      else                    hazard = 1'b1;
    end else if (wb_hit) begin
      if (wb_fw.can_forward) data = wb_fw.wdata;
      else                   hazard = 1'b1;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: ID stage of the RV32IM 5-stage pipeline.
//   clk, reset              clock; synchronous active-high reset
//   regfile[32]             architectural registers, read combinationally
//   id_valid/id_reg_pc/id_inst/id_inst_id   ID pipeline register contents
//   id_exe_valid/_reg_pc/_inst/_inst_id     pass-through to EXE
//   id_exe_ctrl             decoded control bundle with resolved operands
//   dh_exe_fw/dh_mem_fw/dh_wb_fw            forwarding candidates
//   dh_stall_flg            data-hazard stall request
//   zifencei_mem_wen        a store is still valid in EXE or MEM
//   zifencei_stall_flg      fence.i stall request
// Everything is combinational except the one-bit fence.i drain register.
module decode_stage
  import core_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [XLEN-1:0]     regfile [32],
  input  logic                id_valid,
  input  logic [XLEN-1:0]     id_reg_pc,
  input  logic [31:0]         id_inst,
  input  logic [63:0]         id_inst_id,
  output logic                id_exe_valid,
  output logic [XLEN-1:0]     id_exe_reg_pc,
  output logic [31:0]         id_exe_inst,
  output logic [63:0]         id_exe_inst_id,
  output ctrltype             id_exe_ctrl,
  input  fw_ctrltype          dh_exe_fw,
  input  fw_ctrltype          dh_mem_fw,
  input  fw_ctrltype          dh_wb_fw,
  output logic                dh_stall_flg,
  input  logic                zifencei_mem_wen,
  output logic                zifencei_stall_flg
);

  typedef enum logic [1:0] {OP1_ZERO, OP1_RS1, OP1_PC, OP1_IMZ} op1_sel_e;
  typedef enum logic [2:0] {OP2_ZERO, OP2_RS2, OP2_IMI, OP2_IMS, OP2_IMU, OP2_IMJ} op2_sel_e;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rs1;
  logic [4:0] rs2;

  assign opcode = id_inst[6:0];
  assign funct3 = id_inst[14:12];
  assign funct7 = id_inst[31:25];
  assign rs1    = id_inst[19:15];
  assign rs2    = id_inst[24:20];

  // Pass-through of the ID register.
  assign id_exe_valid   = id_valid;
  assign id_exe_reg_pc  = id_reg_pc;
  assign id_exe_inst    = id_inst;
  assign id_exe_inst_id = id_inst_id;

  // ---------------------------------------------------------------------
  // Instruction decode
  // ---------------------------------------------------------------------
  alu_fun_e exe_fun;
  op1_sel_e op1_sel;
  op2_sel_e op2_sel;
  mem_wen_e mem_wen;
  rf_wen_e  rf_wen;
  wb_sel_e  wb_sel;
  csr_cmd_e csr_cmd;
  logic     br_flg;
  logic     jmp_flg;
  logic     use_rs1;
  logic     use_rs2;
  logic     is_fence_i;

  // Any encoding not recognised below leaves the NOP defaults in place, so
  // illegal funct fields inside a known opcode also decode as a NOP.
  always_comb begin
    exe_fun    = ALU_X;
    op1_sel    = OP1_ZERO;
    op2_sel    = OP2_ZERO;
    mem_wen    = MEN_X;
    rf_wen     = REN_X;
    wb_sel     = WB_X;
    csr_cmd    = CSR_X;
    br_flg     = 1'b0;
    jmp_flg    = 1'b0;
    use_rs1    = 1'b0;
    use_rs2    = 1'b0;
    is_fence_i = 1'b0;

    case (opcode)
      OPC_LUI: begin
        exe_fun = ALU_ADD;
        op2_sel = OP2_IMU;
        rf_wen  = REN_S;
        wb_sel  = WB_ALU;
      end

      OPC_AUIPC: begin
        exe_fun = ALU_ADD;
        op1_sel = OP1_PC;
        op2_sel = OP2_IMU;
        rf_wen  = REN_S;
        wb_sel  = WB_ALU;
      end

      OPC_JAL: begin
        exe_fun = ALU_ADD;
        op1_sel = OP1_PC;
        op2_sel = OP2_IMJ;
        rf_wen  = REN_S;
        wb_sel  = WB_PC;
        jmp_flg = 1'b1;
      end

      OPC_JALR: begin
        if (funct3 == 3'b000) begin
          exe_fun = ALU_JALR;
          op1_sel = OP1_RS1;
          op2_sel = OP2_IMI;
          rf_wen  = REN_S;
          wb_sel  = WB_PC;
          jmp_flg = 1'b1;
          use_rs1 = 1'b1;
        end
      end

      OPC_BRANCH: begin
        case (funct3)
          3'b000:  exe_fun = ALU_BEQ;
          3'b001:  exe_fun = ALU_BNE;
          3'b100:  exe_fun = ALU_BLT;
          3'b101:  exe_fun = ALU_BGE;
          3'b110:  exe_fun = ALU_BLTU;
          3'b111:  exe_fun = ALU_BGEU;
          default: exe_fun = ALU_X;
        endcase
        if (exe_fun != ALU_X) begin
          op1_sel = OP1_RS1;
          op2_sel = OP2_RS2;
          br_flg  = 1'b1;
          use_rs1 = 1'b1;
          use_rs2 = 1'b1;
        end
      end

      OPC_LOAD: begin
        case (funct3)
          3'b000:  mem_wen = MEN_LB;
          3'b001:  mem_wen = MEN_LH;
          3'b010:  mem_wen = MEN_LW;
          3'b100:  mem_wen = MEN_LBU;
          3'b101:  mem_wen = MEN_LHU;
          default: mem_wen = MEN_X;
        endcase
        if (mem_wen != MEN_X) begin
          exe_fun = ALU_ADD;
          op1_sel = OP1_RS1;
          op2_sel = OP2_IMI;
          rf_wen  = REN_S;
          wb_sel  = WB_MEM;
          use_rs1 = 1'b1;
        end
      end

      OPC_STORE: begin
        case (funct3)
          3'b000:  mem_wen = MEN_SB;
          3'b001:  mem_wen = MEN_SH;
          3'b010:  mem_wen = MEN_SW;
          default: mem_wen = MEN_X;
        endcase
        if (mem_wen != MEN_X) begin
          exe_fun = ALU_ADD;
          op1_sel = OP1_RS1;
          op2_sel = OP2_IMS;
          use_rs1 = 1'b1;
          use_rs2 = 1'b1;
        end
      end

      OPC_OP_IMM: begin
        case (funct3)
          3'b000:  exe_fun = ALU_ADD;
          3'b010:  exe_fun = ALU_SLT;
          3'b011:  exe_fun = ALU_SLTU;
          3'b100:  exe_fun = ALU_XOR;
          3'b110:  exe_fun = ALU_OR;
          3'b111:  exe_fun = ALU_AND;
          3'b001:  exe_fun = (funct7 == F7_BASE) ? ALU_SLL : ALU_X;
          3'b101:  exe_fun = (funct7 == F7_BASE) ? ALU_SRL :
                             (funct7 == F7_ALT)  ? ALU_SRA : ALU_X;
          default: exe_fun = ALU_X;
        endcase
        if (exe_fun != ALU_X) begin
          op1_sel = OP1_RS1;
          op2_sel = OP2_IMI;
          rf_wen  = REN_S;
          wb_sel  = WB_ALU;
          use_rs1 = 1'b1;
        end
      end

      OPC_OP: begin
        if (funct7 == F7_BASE) begin
          case (funct3)
            3'b000:  exe_fun = ALU_ADD;
            3'b001:  exe_fun = ALU_SLL;
            3'b010:  exe_fun = ALU_SLT;
            3'b011:  exe_fun = ALU_SLTU;
            3'b100:  exe_fun = ALU_XOR;
            3'b101:  exe_fun = ALU_SRL;
            3'b110:  exe_fun = ALU_OR;
            default: exe_fun = ALU_AND;
          endcase
        end else if (funct7 == F7_ALT) begin
          case (funct3)
            3'b000:  exe_fun = ALU_SUB;
            3'b101:  exe_fun = ALU_SRA;
            default: exe_fun = ALU_X;
          endcase
        end else if (funct7 == F7_MULDIV) begin
          case (funct3)
            3'b000:  exe_fun = ALU_MUL;
            3'b001:  exe_fun = ALU_MULH;
            3'b010:  exe_fun = ALU_MULHSU;
            3'b011:  exe_fun = ALU_MULHU;
            3'b100:  exe_fun = ALU_DIV;
            3'b101:  exe_fun = ALU_DIVU;
            3'b110:  exe_fun = ALU_REM;
            default: exe_fun = ALU_REMU;
          endcase
        end
        if (exe_fun != ALU_X) begin
          op1_sel = OP1_RS1;
          op2_sel = OP2_RS2;
          rf_wen  = REN_S;
          wb_sel  = WB_ALU;
          use_rs1 = 1'b1;
          use_rs2 = 1'b1;
        end
      end

      // fence and fence.i both leave the NOP defaults; fence.i only raises
      // the flag that drives the store-drain stall.
      OPC_MISC_MEM: begin
        is_fence_i = (funct3 == F3_FENCE_I);
      end

      OPC_SYSTEM: begin
        case (funct3)
          3'b000: begin
            if (id_inst == INST_ECALL)     csr_cmd = CSR_ECALL;
            else if (id_inst == INST_MRET) csr_cmd = CSR_MRET;
          end
          3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111: begin
            case (funct3[1:0])
              2'b01:   csr_cmd = CSR_W;
              2'b10:   csr_cmd = CSR_S;
              default: csr_cmd = CSR_C;
            endcase
            // The CSR unit takes its source through op1: rs1 for the
            // register forms, the zero-extended uimm for the immediate forms.
            exe_fun = ALU_COPY1;
            rf_wen  = REN_S;
            wb_sel  = WB_CSR;
            if (funct3[2]) begin
              op1_sel = OP1_IMZ;
            end else begin
              op1_sel = OP1_RS1;
              use_rs1 = 1'b1;
            end
          end
          default: csr_cmd = CSR_X;
        endcase
      end

      default: ;
    endcase
  end

  // ---------------------------------------------------------------------
  // Source resolution
  // ---------------------------------------------------------------------
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            rs1_hazard;
  logic            rs2_hazard;

  operand_forward u_fw_rs1 (
    .rs      (rs1),
    .exe_fw  (dh_exe_fw),
    .mem_fw  (dh_mem_fw),
    .wb_fw   (dh_wb_fw),
    .rf_data (regfile[rs1]),
    .data    (rs1_data),
    .hazard  (rs1_hazard)
  );

  operand_forward u_fw_rs2 (
    .rs      (rs2),
    .exe_fw  (dh_exe_fw),
    .mem_fw  (dh_mem_fw),
    .wb_fw   (dh_wb_fw),
    .rf_data (regfile[rs2]),
    .data    (rs2_data),
    .hazard  (rs2_hazard)
  );

  // The register fields of formats that do not read them hold immediate or
  // opcode bits, so their hazards are masked by the format's usage.
  assign dh_stall_flg = id_valid && ((use_rs1 && rs1_hazard) || (use_rs2 && rs2_hazard));

  // ---------------------------------------------------------------------
  // Control bundle
  // ---------------------------------------------------------------------
  always_comb begin
    id_exe_ctrl          = '0;
    id_exe_ctrl.exe_fun  = exe_fun;

    case (op1_sel)
      OP1_RS1: id_exe_ctrl.op1_data = rs1_data;
      OP1_PC:  id_exe_ctrl.op1_data = id_reg_pc;
      OP1_IMZ: id_exe_ctrl.op1_data = {27'd0, rs1};
      default: id_exe_ctrl.op1_data = '0;
    endcase

    case (op2_sel)
      OP2_RS2: id_exe_ctrl.op2_data = rs2_data;
      OP2_IMI: id_exe_ctrl.op2_data = imm_i_of(id_inst);
      OP2_IMS: id_exe_ctrl.op2_data = imm_s_of(id_inst);
      OP2_IMU: id_exe_ctrl.op2_data = imm_u_of(id_inst);
      OP2_IMJ: id_exe_ctrl.op2_data = imm_j_of(id_inst);
      default: id_exe_ctrl.op2_data = '0;
    endcase

    id_exe_ctrl.rs2_data = rs2_data;
    id_exe_ctrl.imm_b    = imm_b_of(id_inst);
    id_exe_ctrl.imm_j    = imm_j_of(id_inst);
    id_exe_ctrl.br_flg   = br_flg;
    id_exe_ctrl.jmp_flg  = jmp_flg;
    id_exe_ctrl.mem_wen  = mem_wen;
    id_exe_ctrl.rf_wen   = rf_wen;
    id_exe_ctrl.wb_sel   = wb_sel;
    id_exe_ctrl.wb_addr  = id_inst[11:7];
    id_exe_ctrl.csr_cmd  = csr_cmd;
    id_exe_ctrl.csr_addr = id_inst[31:20];
  end

  // ---------------------------------------------------------------------
  // fence.i store drain
  // ---------------------------------------------------------------------
  // drain holds the stall for one cycle after the last store was seen, so the
  // store has fully left MEM before instruction fetch is allowed to resume.
  logic drain;

  // NOTE: sequential state uses non-blocking assignments so every register
  // updates from values sampled before the clock edge.
  always_ff @(posedge clk) begin
    if (reset) drain <= 1'b0;
    else       drain <= id_valid && is_fence_i && zifencei_mem_wen;
  end

  assign zifencei_stall_flg = id_valid && is_fence_i && (zifencei_mem_wen || drain);

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: each task drives one scenario and checks
// outputs against hand-computed values. Inputs change on the falling edge and
// outputs are sampled 1 ns later; the drain register updates on rising edges.
module tb_decode_stage;
  import core_pkg::*;

  logic            clk;
  logic            reset;
  logic [31:0]     regfile [32];
  logic            id_valid;
  logic [31:0]     id_reg_pc;
  logic [31:0]     id_inst;
  logic [63:0]     id_inst_id;
  logic            id_exe_valid;
  logic [31:0]     id_exe_reg_pc;
  logic [31:0]     id_exe_inst;
  logic [63:0]     id_exe_inst_id;
  ctrltype         ctrl;
  fw_ctrltype      dh_exe_fw;
  fw_ctrltype      dh_mem_fw;
  fw_ctrltype      dh_wb_fw;
  logic            dh_stall_flg;
  logic            zifencei_mem_wen;
  logic            zifencei_stall_flg;

  int checks = 0;
  int errors = 0;

  decode_stage dut (
    .clk                (clk),
    .reset              (reset),
    .regfile            (regfile),
    .id_valid           (id_valid),
    .id_reg_pc          (id_reg_pc),
    .id_inst            (id_inst),
    .id_inst_id         (id_inst_id),
    .id_exe_valid       (id_exe_valid),
    .id_exe_reg_pc      (id_exe_reg_pc),
    .id_exe_inst        (id_exe_inst),
    .id_exe_inst_id     (id_exe_inst_id),
    .id_exe_ctrl        (ctrl),
    .dh_exe_fw          (dh_exe_fw),
    .dh_mem_fw          (dh_mem_fw),
    .dh_wb_fw           (dh_wb_fw),
    .dh_stall_flg       (dh_stall_flg),
    .zifencei_mem_wen   (zifencei_mem_wen),
    .zifencei_stall_flg (zifencei_stall_flg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] I_ADDI_X1_X0_5  = 32'h0050_0093;
  localparam logic [31:0] I_ADD_X3_X1_X2  = 32'h0020_81B3;
  localparam logic [31:0] I_ADDI_X2_X1_1  = 32'h0010_8113;
  localparam logic [31:0] I_ADDI_X2_X0_1  = 32'h0010_0113;
  localparam logic [31:0] I_ADDI_X6_X5_0  = 32'h0002_8313;
  localparam logic [31:0] I_SW_X2_8_X1    = 32'h0020_A423;
  localparam logic [31:0] I_BEQ_M4        = 32'hFE20_8EE3;
  localparam logic [31:0] I_LUI_X5        = 32'h1234_52B7;
  localparam logic [31:0] I_JAL_X1_8      = 32'h0080_00EF;
  localparam logic [31:0] I_MUL_X3_X1_X2  = 32'h0220_81B3;
  localparam logic [31:0] I_CSRRS_X5_X1   = 32'h3000_A2F3;
  localparam logic [31:0] I_ECALL         = 32'h0000_0073;
  localparam logic [31:0] I_MRET          = 32'h3020_0073;
  localparam logic [31:0] I_FENCE_I       = 32'h0000_100F;
  localparam logic [31:0] I_UNKNOWN       = 32'hFFFF_FFFF;

  function automatic fw_ctrltype mk_fw(input logic v, input logic cf,
                                       input logic [4:0] a, input logic [31:0] d);
    fw_ctrltype f;
    f.valid = v;
    f.can_forward = cf;
    f.addr = a;
    f.wdata = d;
    return f;
  endfunction

  task automatic apply(input logic [31:0] inst);
    @(negedge clk);
    id_valid   = 1'b1;
    id_inst    = inst;
    id_reg_pc  = 32'h0000_0100;
    id_inst_id = 64'hCAFE_0000_0000_0001;
    #1;
  endtask

  task automatic clear_fw();
    dh_exe_fw = '0;
    dh_mem_fw = '0;
    dh_wb_fw  = '0;
  endtask

  task automatic test_reset();
    id_valid = 1'b1;
    id_inst = I_FENCE_I;
    zifencei_mem_wen = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (zifencei_stall_flg !== 1'b0) begin
      errors++;
      $display("FAIL reset_fencei_flag got %0b want 0", zifencei_stall_flg);
    end
    checks++;
    if (dh_stall_flg !== 1'b0) begin
      errors++;
      $display("FAIL reset_dh_stall got %0b want 0", dh_stall_flg);
    end
  endtask

  task automatic test_addi();
    clear_fw();
    apply(I_ADDI_X1_X0_5);
    checks++;
    if (ctrl.op2_data !== 32'd5) begin
      errors++; $display("FAIL addi_op2 got %h want 00000005", ctrl.op2_data);
    end
    checks++;
    if (ctrl.op1_data !== 32'd0) begin
      errors++; $display("FAIL addi_op1_x0 got %h want 00000000", ctrl.op1_data);
    end
    checks++;
    if (ctrl.rf_wen !== REN_S || ctrl.wb_sel !== WB_ALU || ctrl.wb_addr !== 5'd1) begin
      errors++;
      $display("FAIL addi_wb got rf_wen=%0d wb_sel=%0d wb_addr=%0d want 1 1 1",
               ctrl.rf_wen, ctrl.wb_sel, ctrl.wb_addr);
    end
    checks++;
    if (dh_stall_flg !== 1'b0) begin
      errors++; $display("FAIL addi_stall got %0b want 0", dh_stall_flg);
    end
    checks++;
    if (id_exe_valid !== 1'b1 || id_exe_reg_pc !== 32'h100 || id_exe_inst !== I_ADDI_X1_X0_5 ||
        id_exe_inst_id !== 64'hCAFE_0000_0000_0001) begin
      errors++;
      $display("FAIL passthrough got v=%0b pc=%h inst=%h id=%h", id_exe_valid, id_exe_reg_pc,
               id_exe_inst, id_exe_inst_id);
    end
  endtask

  task automatic test_forward();
    clear_fw();
    apply(I_ADD_X3_X1_X2);
    checks++;
    if (ctrl.op1_data !== 32'h1001 || ctrl.op2_data !== 32'h1002) begin
      errors++;
      $display("FAIL regfile_read got %h %h want 00001001 00001002", ctrl.op1_data, ctrl.op2_data);
    end
    dh_mem_fw = mk_fw(1'b1, 1'b1, 5'd1, 32'h11);
    dh_wb_fw  = mk_fw(1'b1, 1'b1, 5'd2, 32'h22);
    #1;
    checks++;
    if (ctrl.op1_data !== 32'h11 || ctrl.op2_data !== 32'h22 || dh_stall_flg !== 1'b0) begin
      errors++;
      $display("FAIL fwd_mem_wb got %h %h stall=%0b want 00000011 00000022 0",
               ctrl.op1_data, ctrl.op2_data, dh_stall_flg);
    end
    checks++;
    if (ctrl.exe_fun !== ALU_ADD) begin
      errors++; $display("FAIL add_fun got %0d want %0d", ctrl.exe_fun, ALU_ADD);
    end
  endtask

  task automatic test_exe_stall();
    clear_fw();
    apply(I_ADD_X3_X1_X2);
    dh_exe_fw = mk_fw(1'b1, 1'b0, 5'd1, 32'h99);
    // An older MEM entry that could forward must not override the EXE match.
    dh_mem_fw = mk_fw(1'b1, 1'b1, 5'd1, 32'h55);
    #1;
    checks++;
    if (dh_stall_flg !== 1'b1) begin
      errors++; $display("FAIL exe_stall got %0b want 1", dh_stall_flg);
    end
    id_valid = 1'b0;
    #1;
    checks++;
    if (dh_stall_flg !== 1'b0) begin
      errors++; $display("FAIL exe_stall_invalid got %0b want 0", dh_stall_flg);
    end
  endtask

  task automatic test_load_use();
    clear_fw();
    dh_mem_fw = mk_fw(1'b1, 1'b0, 5'd1, 32'h77);
    apply(I_ADDI_X2_X1_1);
    checks++;
    if (dh_stall_flg !== 1'b1) begin
      errors++; $display("FAIL load_use got %0b want 1", dh_stall_flg);
    end
    apply(I_ADDI_X2_X0_1);
    checks++;
    if (dh_stall_flg !== 1'b0 || ctrl.op1_data !== 32'd0) begin
      errors++;
      $display("FAIL load_use_x0 got stall=%0b op1=%h want 0 00000000", dh_stall_flg, ctrl.op1_data);
    end
  endtask

  task automatic test_priority();
    clear_fw();
    dh_mem_fw = mk_fw(1'b1, 1'b1, 5'd5, 32'hA);
    dh_wb_fw  = mk_fw(1'b1, 1'b1, 5'd5, 32'hB);
    apply(I_ADDI_X6_X5_0);
    checks++;
    if (ctrl.op1_data !== 32'hA) begin
      errors++; $display("FAIL priority got %h want 0000000a", ctrl.op1_data);
    end
  endtask

  task automatic test_formats();
    clear_fw();
    apply(I_SW_X2_8_X1);
    checks++;
    if (ctrl.mem_wen !== MEN_SW || ctrl.op2_data !== 32'd8 || ctrl.rs2_data !== 32'h1002 ||
        ctrl.rf_wen !== REN_X) begin
      errors++;
      $display("FAIL store got men=%0d op2=%h rs2=%h ren=%0d", ctrl.mem_wen, ctrl.op2_data,
               ctrl.rs2_data, ctrl.rf_wen);
    end
    apply(I_BEQ_M4);
    checks++;
    if (ctrl.imm_b !== 32'hFFFF_FFFC || ctrl.br_flg !== 1'b1 || ctrl.exe_fun !== ALU_BEQ) begin
      errors++;
      $display("FAIL branch got imm_b=%h br=%0b fun=%0d want fffffffc 1 %0d",
               ctrl.imm_b, ctrl.br_flg, ctrl.exe_fun, ALU_BEQ);
    end
    // LUI's rs1/rs2 fields (x8, x3) hold immediate bits: no hazard allowed.
    dh_exe_fw = mk_fw(1'b1, 1'b0, 5'd8, 32'h0);
    dh_mem_fw = mk_fw(1'b1, 1'b0, 5'd3, 32'h0);
    apply(I_LUI_X5);
    checks++;
    if (ctrl.op2_data !== 32'h1234_5000 || ctrl.op1_data !== 32'd0 || dh_stall_flg !== 1'b0) begin
      errors++;
      $display("FAIL lui got op2=%h op1=%h stall=%0b want 12345000 00000000 0",
               ctrl.op2_data, ctrl.op1_data, dh_stall_flg);
    end
    clear_fw();
    apply(I_JAL_X1_8);
    checks++;
    if (ctrl.imm_j !== 32'd8 || ctrl.op1_data !== 32'h100 || ctrl.wb_sel !== WB_PC ||
        ctrl.jmp_flg !== 1'b1) begin
      errors++;
      $display("FAIL jal got imm_j=%h op1=%h wb=%0d jmp=%0b", ctrl.imm_j, ctrl.op1_data,
               ctrl.wb_sel, ctrl.jmp_flg);
    end
    apply(I_MUL_X3_X1_X2);
    checks++;
    if (ctrl.exe_fun !== ALU_MUL) begin
      errors++; $display("FAIL mul got %0d want %0d", ctrl.exe_fun, ALU_MUL);
    end
  endtask

  task automatic test_system();
    clear_fw();
    apply(I_CSRRS_X5_X1);
    checks++;
    if (ctrl.csr_cmd !== CSR_S || ctrl.csr_addr !== 12'h300 || ctrl.op1_data !== 32'h1001 ||
        ctrl.wb_sel !== WB_CSR) begin
      errors++;
      $display("FAIL csrrs got cmd=%0d addr=%h op1=%h wb=%0d", ctrl.csr_cmd, ctrl.csr_addr,
               ctrl.op1_data, ctrl.wb_sel);
    end
    apply(I_ECALL);
    checks++;
    if (ctrl.csr_cmd !== CSR_ECALL) begin
      errors++; $display("FAIL ecall got %0d want %0d", ctrl.csr_cmd, CSR_ECALL);
    end
    apply(I_MRET);
    checks++;
    if (ctrl.csr_cmd !== CSR_MRET) begin
      errors++; $display("FAIL mret got %0d want %0d", ctrl.csr_cmd, CSR_MRET);
    end
    apply(I_UNKNOWN);
    checks++;
    if (ctrl.rf_wen !== REN_X || ctrl.mem_wen !== MEN_X || ctrl.csr_cmd !== CSR_X ||
        ctrl.br_flg !== 1'b0 || ctrl.jmp_flg !== 1'b0) begin
      errors++;
      $display("FAIL unknown_nop got ren=%0d men=%0d csr=%0d br=%0b jmp=%0b", ctrl.rf_wen,
               ctrl.mem_wen, ctrl.csr_cmd, ctrl.br_flg, ctrl.jmp_flg);
    end
  endtask

  task automatic test_fence_i();
    clear_fw();
    // Stores seen for two cycles: stall holds for those plus one drain cycle.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      id_valid = 1'b1;
      id_inst = I_FENCE_I;
      zifencei_mem_wen = (i < 2);
      #1;
      checks++;
      if (zifencei_stall_flg !== (i < 3)) begin
        errors++;
        $display("FAIL fencei_cycle%0d got %0b want %0b", i, zifencei_stall_flg, (i < 3));
      end
    end
    checks++;
    if (ctrl.rf_wen !== REN_X || ctrl.mem_wen !== MEN_X || dh_stall_flg !== 1'b0) begin
      errors++;
      $display("FAIL fencei_nop got ren=%0d men=%0d stall=%0b", ctrl.rf_wen, ctrl.mem_wen,
               dh_stall_flg);
    end
  endtask

  task automatic test_reset_mid_stall();
    @(negedge clk);
    id_valid = 1'b1;
    id_inst = I_FENCE_I;
    zifencei_mem_wen = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    zifencei_mem_wen = 1'b0;
    #1;
    checks++;
    if (zifencei_stall_flg !== 1'b0) begin
      errors++; $display("FAIL reset_mid_stall got %0b want 0", zifencei_stall_flg);
    end
    @(negedge clk);
    zifencei_mem_wen = 1'b1;
    #1;
    checks++;
    if (zifencei_stall_flg !== 1'b1) begin
      errors++; $display("FAIL after_reset_follow got %0b want 1", zifencei_stall_flg);
    end
    @(negedge clk);
    zifencei_mem_wen = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regfile[i] = 32'h1000 + i;
    // A non-zero x0 slot makes the hard-wired-zero rule observable.
    regfile[0] = 32'hBAD0_0000;
    id_valid = 1'b0;
    id_reg_pc = '0;
    id_inst = '0;
    id_inst_id = '0;
    zifencei_mem_wen = 1'b0;
    reset = 1'b1;
    clear_fw();

    test_reset();
    test_addi();
    test_forward();
    test_exe_stall();
    test_load_use();
    test_priority();
    test_formats();
    test_system();
    test_fence_i();
    test_reset_mid_stall();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
